// File: rtl/dmem_responder_pkg.sv
// Shared load/store op encodings and FSM state type for the data-memory responder.
// NONE is encoded as zero for both op fields so an idle decode drives all-zero.
package dmem_responder_pkg;

    localparam int STORE_W = 2;
    localparam int LOAD_W  = 3;

    typedef enum logic [STORE_W-1:0] {
        STORE_NONE = 2'd0,
        STORE_SB   = 2'd1,
        STORE_SH   = 2'd2,
        STORE_SW   = 2'd3
    } store_op_e;

    typedef enum logic [LOAD_W-1:0] {
        LOAD_NONE = 3'd0,
        LOAD_LB   = 3'd1,
        LOAD_LH   = 3'd2,
        LOAD_LW   = 3'd3,
        LOAD_LBU  = 3'd4,
        LOAD_LHU  = 3'd5
    } load_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_lane_ext.sv
// Byte-lane write-mask/data generation and load extraction/extension (combinational).
// With DMEM_MISALIGN_CHECK_EN defined, misaligned halfword/word accesses flag misalign_o.
module dmem_lane_ext
    import dmem_responder_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]         addr_lo_i,
    input  logic [STORE_W-1:0] store_op_i,
    input  logic [LOAD_W-1:0]  load_op_i,
    input  logic [XLEN-1:0]    wdata_i,
    input  logic [XLEN-1:0]    rword_i,
    output logic [3:0]         wmask_o,
    output logic [XLEN-1:0]    wdata_o,
    output logic [XLEN-1:0]    rdata_o,
    output logic               misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        wmask_o = 4'b0000;
        wdata_o = wdata_i;
        case (store_op_i)
            STORE_SB: begin
                wmask_o = 4'b0001 << addr_lo_i;
                wdata_o = {(XLEN/8){wdata_i[7:0]}};
            end
            STORE_SH: begin
                wmask_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {(XLEN/16){wdata_i[15:0]}};
            end
            STORE_SW: wmask_o = 4'b1111;
            default:  wmask_o = 4'b0000;
        endcase
    end

    always_comb begin
        byte_sel = rword_i[8*addr_lo_i +: 8];
        half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        rdata_o  = '0;
        case (load_op_i)
            LOAD_LB:  rdata_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LOAD_LBU: rdata_o = {{(XLEN-8){1'b0}}, byte_sel};
            LOAD_LH:  rdata_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            LOAD_LHU: rdata_o = {{(XLEN-16){1'b0}}, half_sel};
            LOAD_LW:  rdata_o = rword_i;
            default:  rdata_o = '0;
        endcase
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    always_comb begin
        misalign_o = 1'b0;
        if (store_op_i == STORE_SH || load_op_i == LOAD_LH || load_op_i == LOAD_LHU)
            misalign_o = addr_lo_i[0];
        if (store_op_i == STORE_SW || load_op_i == LOAD_LW)
            misalign_o = (addr_lo_i != 2'b00);
    end
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request in, fixed-latency response out.
// Misalignment errors are enabled by DMEM_MISALIGN_CHECK_EN (see dmem_lane_ext).
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [XLEN-1:0]    req_addr_i,
    input  logic [XLEN-1:0]    req_wdata_i,
    input  logic [STORE_W-1:0] req_store_op_i,
    input  logic [LOAD_W-1:0]  req_load_op_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [XLEN-1:0]    rsp_rdata_o,
    output logic               rsp_err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int AW    = IDX_W + 2;
    localparam bit LAT0  = (LATENCY == 0);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [AW-1:0]      addr_q;
    logic [XLEN-1:0]    wdata_q;
    logic [STORE_W-1:0] st_q;
    logic [LOAD_W-1:0]  ld_q;
    logic [XLEN-1:0]    rdata_q;
    logic               err_q;

    logic [XLEN-1:0]    mem_q [DEPTH_WORDS];

    logic               accept, commit, use_in;
    logic [AW-1:0]      ex_addr;
    logic [XLEN-1:0]    ex_wdata, rword, lane_wdata, lane_rdata;
    logic [STORE_W-1:0] ex_st;
    logic [LOAD_W-1:0]  ex_ld;
    logic [IDX_W-1:0]   ex_idx;
    logic [3:0]         wmask;
    logic               misalign, ex_err, mem_we;
    logic               unused_addr;

    assign unused_addr = ^req_addr_i[XLEN-1:AW];

    assign accept = (state_q == ST_IDLE) && req_valid_i;
    // The op executes on the edge entering RESP; with zero latency that is the accept edge itself.
    assign commit = (accept && LAT0) || (state_q == ST_WAIT && cnt_q == 4'd0);
    assign use_in = (state_q == ST_IDLE);

    assign ex_addr  = use_in ? req_addr_i[AW-1:0] : addr_q;
    assign ex_wdata = use_in ? req_wdata_i : wdata_q;
    assign ex_st    = use_in ? req_store_op_i : st_q;
    assign ex_ld    = use_in ? req_load_op_i : ld_q;
    assign ex_idx   = ex_addr[AW-1:2];
    assign rword    = mem_q[ex_idx];

    dmem_lane_ext #(.XLEN(XLEN)) u_lane_ext (
        .addr_lo_i  (ex_addr[1:0]),
        .store_op_i (ex_st),
        .load_op_i  (ex_ld),
        .wdata_i    (ex_wdata),
        .rword_i    (rword),
        .wmask_o    (wmask),
        .wdata_o    (lane_wdata),
        .rdata_o    (lane_rdata),
        .misalign_o (misalign)
    );

    assign ex_err = ((ex_st != STORE_NONE) && (ex_ld != LOAD_NONE)) || misalign;
    assign mem_we = commit && rst_n_i && !ex_err && (ex_st != STORE_NONE);

    // NOTE: the array is deliberately left without reset so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (wmask[b]) mem_q[ex_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            st_q    <= '0;
            ld_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= req_addr_i[AW-1:0];
                wdata_q <= req_wdata_i;
                st_q    <= req_store_op_i;
                ld_q    <= req_load_op_i;
            end
            if (commit) begin
                rdata_q <= (ex_ld != LOAD_NONE && !ex_err) ? lane_rdata : '0;
                err_q   <= ex_err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (req_valid_i) begin
                state_d = LAT0 ? ST_RESP : ST_WAIT;
                cnt_d   = LAT0 ? 4'd0 : 4'(LATENCY - 1);
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == ST_IDLE);
        rsp_valid_o = (state_q == ST_RESP);
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2, DEPTH_WORDS=1024): vector table plus
// backpressure and reset corner sequences.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int LAT = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [31:0]        req_addr;
    logic [31:0]        req_wdata;
    logic [STORE_W-1:0] req_st;
    logic [LOAD_W-1:0]  req_ld;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_store_op_i (req_st),
        .req_load_op_i  (req_ld),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err)
    );

    typedef struct {
        string              name;
        logic [STORE_W-1:0] st;
        logic [LOAD_W-1:0]  ld;
        logic [31:0]        addr;
        logic [31:0]        wdata;
        logic [31:0]        exp_rdata;
        logic               exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request, returning the response seen once rsp_valid rises and the
    // number of cycles from the accept cycle to that point (40 means timed out).
    task automatic run_req(input string name, input logic [STORE_W-1:0] st,
                           input logic [LOAD_W-1:0] ld, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd,
                           output logic er, output int lat);
        @(negedge clk);
        check({name, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_st    = st;
        req_ld    = ld;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] rd;
        logic [31:0] held;
        logic        er;
        int          lat;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_st    = STORE_NONE;
        req_ld    = LOAD_NONE;
        rsp_ready = 1'b1;

        vecs.push_back('{"sw_10",   STORE_SW,   LOAD_NONE, 32'h10,   32'h8000_00FF, 32'h0,          1'b0});
        vecs.push_back('{"lw_10",   STORE_NONE, LOAD_LW,   32'h10,   32'h0,         32'h8000_00FF, 1'b0});
        vecs.push_back('{"sb_11",   STORE_SB,   LOAD_NONE, 32'h11,   32'hAA,        32'h0,          1'b0});
        vecs.push_back('{"lbu_11",  STORE_NONE, LOAD_LBU,  32'h11,   32'h0,         32'h0000_00AA, 1'b0});
        vecs.push_back('{"lb_11",   STORE_NONE, LOAD_LB,   32'h11,   32'h0,         32'hFFFF_FFAA, 1'b0});
        vecs.push_back('{"lw_10b",  STORE_NONE, LOAD_LW,   32'h10,   32'h0,         32'h8000_AAFF, 1'b0});
        vecs.push_back('{"lhu_12",  STORE_NONE, LOAD_LHU,  32'h12,   32'h0,         32'h0000_8000, 1'b0});
        vecs.push_back('{"sw_1000", STORE_SW,   LOAD_NONE, 32'h1000, 32'h1234,      32'h0,          1'b0});
        vecs.push_back('{"lw_wrap", STORE_NONE, LOAD_LW,   32'h0,    32'h0,         32'h0000_1234, 1'b0});
        vecs.push_back('{"sw_30",   STORE_SW,   LOAD_NONE, 32'h30,   32'h1122_3344, 32'h0,          1'b0});
        vecs.push_back('{"sh_32",   STORE_SH,   LOAD_NONE, 32'h32,   32'h5A5A_BEEF, 32'h0,          1'b0});
        vecs.push_back('{"lw_30",   STORE_NONE, LOAD_LW,   32'h30,   32'h0,         32'hBEEF_3344, 1'b0});
        vecs.push_back('{"lh_30",   STORE_NONE, LOAD_LH,   32'h30,   32'h0,         32'h0000_3344, 1'b0});
        vecs.push_back('{"lh_32",   STORE_NONE, LOAD_LH,   32'h32,   32'h0,         32'hFFFF_BEEF, 1'b0});
        vecs.push_back('{"both",    STORE_SW,   LOAD_LW,   32'h30,   32'h0,         32'h0,          1'b1});
        vecs.push_back('{"lw_30c",  STORE_NONE, LOAD_LW,   32'h30,   32'h0,         32'hBEEF_3344, 1'b0});
        vecs.push_back('{"nop",     STORE_NONE, LOAD_NONE, 32'h30,   32'hFFFF_FFFF, 32'h0,          1'b0});
`ifdef DMEM_MISALIGN_CHECK_EN
        vecs.push_back('{"lh_13",   STORE_NONE, LOAD_LH,   32'h13,   32'h0,         32'h0,          1'b1});
`else
        vecs.push_back('{"lh_13",   STORE_NONE, LOAD_LH,   32'h13,   32'h0,         32'hFFFF_8000, 1'b0});
`endif
        vecs.push_back('{"sw_20",   STORE_SW,   LOAD_NONE, 32'h20,   32'h0000_CAFE, 32'h0,          1'b0});

        #12;
        check("rst ready", 32'(req_ready), 32'd1);
        check("rst valid", 32'(rsp_valid), 32'd0);
        check("rst rdata", rsp_rdata, 32'h0);
        check("rst err",   32'(rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_req(vecs[i].name, vecs[i].st, vecs[i].ld, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check({vecs[i].name, " latency"}, 32'(lat), 32'(LAT + 1));
            check({vecs[i].name, " rdata"}, rd, vecs[i].exp_rdata);
            check({vecs[i].name, " err"}, 32'(er), 32'(vecs[i].exp_err));
            @(negedge clk);
            check({vecs[i].name, " done"}, 32'(rsp_valid), 32'd0);
        end

        // Backpressure: response must hold for 5 stalled cycles.
        rsp_ready = 1'b0;
        run_req("bp", STORE_NONE, LOAD_LW, 32'h10, 32'h0, rd, er, lat);
        check("bp latency", 32'(lat), 32'(LAT + 1));
        check("bp rdata", rd, 32'h8000_AAFF);
        held = rd;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp hold valid", 32'(rsp_valid), 32'd1);
            check("bp hold rdata", rsp_rdata, held);
            check("bp hold ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp after valid", 32'(rsp_valid), 32'd0);
        check("bp after ready", 32'(req_ready), 32'd1);

        // Reset during WAIT of a store: store discarded, outputs drop at once.
        @(negedge clk);
        req_valid = 1'b1;
        req_st    = STORE_SW;
        req_ld    = LOAD_NONE;
        req_addr  = 32'h20;
        req_wdata = 32'h0000_5555;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_st = STORE_NONE;
        @(negedge clk);
        check("wait state ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst wait valid", 32'(rsp_valid), 32'd0);
        check("rst wait ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_req("lw_20", STORE_NONE, LOAD_LW, 32'h20, 32'h0, rd, er, lat);
        check("lw_20 rdata", rd, 32'h0000_CAFE);
        @(negedge clk);

        // Reset while in RESP: rsp_valid falls asynchronously.
        rsp_ready = 1'b0;
        run_req("rr", STORE_NONE, LOAD_LW, 32'h20, 32'h0, rd, er, lat);
        check("rr valid", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst resp valid", 32'(rsp_valid), 32'd0);
        check("rst resp ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
